// File: rtl/writeback_regfile.sv
// Writeback stage with an 8 x 16-bit register file.
// Selects load data or the ALU result, commits it to the destination register
// when a write is requested and the stage is not stalled, and registers the
// last written register/value for execute-stage forwarding plus a running
// count of committed writes.
//
// Optional feature, selected by macro WB_BYPASS_EN:
//   defined   -> write-through bypass: a read of the register being written
//                this cycle returns the incoming writeback data immediately.
//   undefined -> reads return the stored (pre-write) value until the edge.
`default_nettype none

module writeback_regfile #(
  parameter logic [15:0] RESET_VALUE = 16'h0000,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [15:0]            readOutData,
  input  logic [15:0]            aluOutData,
  input  logic                   readoutselect,
  input  logic                   WriteRegp4,
  input  logic [2:0]             RegAddressp4,
  input  logic                   hold,
  input  logic [2:0]             rdAddr1,
  input  logic [2:0]             rdAddr2,
  output logic [15:0]            rdData1,
  output logic [15:0]            rdData2,
  output logic                   fwdValid,
  output logic [2:0]             fwdAddr,
  output logic [15:0]            fwdData,
  output logic [COUNT_WIDTH-1:0] wbCount
);

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;

  logic [DATA_W-1:0]      wb_data_c;
  logic                   commit_c;

  logic [DATA_W-1:0]      regs_q [NUM_REGS];
  logic [DATA_W-1:0]      regs_d [NUM_REGS];

  logic                   fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0]      fwd_addr_q,  fwd_addr_d;
  logic [DATA_W-1:0]      fwd_data_q,  fwd_data_d;
  logic [COUNT_WIDTH-1:0] count_q,     count_d;

  // Writeback data mux and commit qualifier (a stall suppresses the write).
  always_comb begin
    wb_data_c = readoutselect ? readOutData : aluOutData;
    commit_c  = WriteRegp4 & ~hold;
  end

  // Next-state for the register array: only the destination changes on commit.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (commit_c) begin
      regs_d[RegAddressp4] = wb_data_c;
    end
  end

  // Next-state for forwarding info and the commit counter.
  always_comb begin
    fwd_valid_d = 1'b0;
    fwd_addr_d  = fwd_addr_q;
    fwd_data_d  = fwd_data_q;
    count_d     = count_q;
    if (commit_c) begin
      fwd_valid_d = 1'b1;
      fwd_addr_d  = RegAddressp4;
      fwd_data_d  = wb_data_c;
      count_d     = count_q + COUNT_WIDTH'(1);
    end
  end

  // Register array; every entry, including r0, is a real writable register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Forwarding registers and wrapping commit counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      count_q     <= '0;
    end else begin
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      count_q     <= count_d;
    end
  end

  // Two independent combinational read ports, optionally bypassing the write.
  always_comb begin
    rdData1 = regs_q[rdAddr1];
    rdData2 = regs_q[rdAddr2];
`ifdef WB_BYPASS_EN
    if (commit_c && (rdAddr1 == RegAddressp4)) begin
      rdData1 = wb_data_c;
    end
    if (commit_c && (rdAddr2 == RegAddressp4)) begin
      rdData2 = wb_data_c;
    end
`else
`endif
  end

  assign fwdValid = fwd_valid_q;
  assign fwdAddr  = fwd_addr_q;
  assign fwdData  = fwd_data_q;
  assign wbCount  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: table-driven write sequence,
// scoreboard of committed writes matched against the forwarding outputs,
// and hand-written sequences for bypass, counter wrap and async reset.
`timescale 1ns/1ps

module tb_writeback_regfile;

  localparam int unsigned CW = 8;

  logic          clock;
  logic          reset_n;
  logic [15:0]   readOutData;
  logic [15:0]   aluOutData;
  logic          readoutselect;
  logic          WriteRegp4;
  logic [2:0]    RegAddressp4;
  logic          hold;
  logic [2:0]    rdAddr1;
  logic [2:0]    rdAddr2;
  logic [15:0]   rdData1;
  logic [15:0]   rdData2;
  logic          fwdValid;
  logic [2:0]    fwdAddr;
  logic [15:0]   fwdData;
  logic [CW-1:0] wbCount;

  writeback_regfile #(
    .RESET_VALUE (16'h0000),
    .COUNT_WIDTH (CW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .readOutData   (readOutData),
    .aluOutData    (aluOutData),
    .readoutselect (readoutselect),
    .WriteRegp4    (WriteRegp4),
    .RegAddressp4  (RegAddressp4),
    .hold          (hold),
    .rdAddr1       (rdAddr1),
    .rdAddr2       (rdAddr2),
    .rdData1       (rdData1),
    .rdData2       (rdData2),
    .fwdValid      (fwdValid),
    .fwdAddr       (fwdAddr),
    .fwdData       (fwdData),
    .wbCount       (wbCount)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int tests;
  int fails;

  logic [15:0]   m_regs [8];
  logic [CW-1:0] m_cnt;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } sb_t;
  sb_t sbq[$];

  typedef struct packed {
    logic        rsel;
    logic [15:0] rdat;
    logic [15:0] adat;
    logic        we;
    logic [2:0]  addr;
    logic        hd;
    logic        exp_fv;
    logic [2:0]  exp_fa;
    logic [15:0] exp_fd;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Read every address on both ports (port 2 walks backwards) and compare.
  task automatic read_all(input string name, input logic [15:0] exp [8]);
    WriteRegp4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rdAddr1 = 3'(i);
      rdAddr2 = 3'(7 - i);
      #1;
      check($sformatf("%s_rd1_r%0d", name, i), 32'(rdData1), 32'(exp[i]));
      check($sformatf("%s_rd2_r%0d", name, 7 - i), 32'(rdData2), 32'(exp[7 - i]));
    end
  endtask

  // One clock of stimulus, entered and left at a falling edge.
  task automatic cycle(input logic rsel, input logic [15:0] rd, input logic [15:0] ad,
                       input logic we, input logic [2:0] addr, input logic hd,
                       input logic [2:0] r1, input logic [2:0] r2);
    logic [15:0] wb;
    logic        commit;
    logic [15:0] e1, e2;
    sb_t         item;
    readoutselect = rsel;
    readOutData   = rd;
    aluOutData    = ad;
    WriteRegp4    = we;
    RegAddressp4  = addr;
    hold          = hd;
    rdAddr1       = r1;
    rdAddr2       = r2;
    #1;
    wb     = rsel ? rd : ad;
    commit = we & ~hd;
    e1 = m_regs[r1];
    e2 = m_regs[r2];
`ifdef WB_BYPASS_EN
    if (commit && r1 == addr) e1 = wb;
    if (commit && r2 == addr) e2 = wb;
`endif
    check("rdData1_pre_edge", 32'(rdData1), 32'(e1));
    check("rdData2_pre_edge", 32'(rdData2), 32'(e2));
    if (commit) begin
      m_regs[addr] = wb;
      m_cnt        = m_cnt + CW'(1);
      item.addr    = addr;
      item.data    = wb;
      sbq.push_back(item);
    end
    @(negedge clock);
    check("fwdValid", 32'(fwdValid), 32'(commit));
    if (fwdValid === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_pop actual=fwdValid_1 required=no_pending_write");
      end else begin
        item = sbq.pop_front();
        check("sb_fwdAddr", 32'(fwdAddr), 32'(item.addr));
        check("sb_fwdData", 32'(fwdData), 32'(item.data));
      end
    end
    sbq.delete();
    check("wbCount", 32'(wbCount), 32'(m_cnt));
  endtask

  vec_t        vecs [7];
  logic [15:0] zeros [8];
  logic [15:0] exp_regs [8];
  logic [15:0] pre7;

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = 16'h0000;
      zeros[i]  = 16'h0000;
    end
    m_cnt = '0;

    // rsel rdat adat we addr hold | fv fa fd cnt
    vecs[0] = '{1'b0, 16'h0000, 16'h1234, 1'b1, 3'd3, 1'b0, 1'b1, 3'd3, 16'h1234, 8'd1};
    vecs[1] = '{1'b1, 16'hBEEF, 16'h0000, 1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 16'hBEEF, 8'd2};
    vecs[2] = '{1'b0, 16'h0000, 16'h5555, 1'b1, 3'd2, 1'b1, 1'b0, 3'd5, 16'hBEEF, 8'd2};
    vecs[3] = '{1'b0, 16'h0000, 16'h7777, 1'b0, 3'd6, 1'b0, 1'b0, 3'd5, 16'hBEEF, 8'd2};
    vecs[4] = '{1'b1, 16'h0F0F, 16'hAAAA, 1'b1, 3'd0, 1'b0, 1'b1, 3'd0, 16'h0F0F, 8'd3};
    vecs[5] = '{1'b0, 16'hCCCC, 16'h1111, 1'b1, 3'd4, 1'b0, 1'b1, 3'd4, 16'h1111, 8'd4};
    vecs[6] = '{1'b0, 16'hCCCC, 16'h2222, 1'b1, 3'd4, 1'b0, 1'b1, 3'd4, 16'h2222, 8'd5};

    exp_regs = '{16'h0F0F, 16'h0000, 16'h0000, 16'h1234,
                 16'h2222, 16'hBEEF, 16'h0000, 16'h0000};

    // Reset with a write request present: it must be discarded.
    reset_n       = 1'b0;
    readoutselect = 1'b0;
    readOutData   = 16'h0000;
    aluOutData    = 16'hDEAD;
    WriteRegp4    = 1'b1;
    RegAddressp4  = 3'd1;
    hold          = 1'b0;
    rdAddr1       = 3'd0;
    rdAddr2       = 3'd0;
    @(negedge clock);
    @(negedge clock);
    check("reset_fwdValid", 32'(fwdValid), 32'd0);
    check("reset_fwdAddr", 32'(fwdAddr), 32'd0);
    check("reset_fwdData", 32'(fwdData), 32'd0);
    check("reset_wbCount", 32'(wbCount), 32'd0);
    read_all("reset", zeros);
    @(negedge clock);
    reset_n = 1'b1;

    // Table-driven sequence: mux select, hold, r0 write, back-to-back same address.
    for (int v = 0; v < 7; v++) begin
      cycle(vecs[v].rsel, vecs[v].rdat, vecs[v].adat, vecs[v].we, vecs[v].addr,
            vecs[v].hd, vecs[v].addr, vecs[v].addr);
      check($sformatf("vec%0d_fwdValid", v), 32'(fwdValid), 32'(vecs[v].exp_fv));
      check($sformatf("vec%0d_fwdAddr", v), 32'(fwdAddr), 32'(vecs[v].exp_fa));
      check($sformatf("vec%0d_fwdData", v), 32'(fwdData), 32'(vecs[v].exp_fd));
      check($sformatf("vec%0d_wbCount", v), 32'(wbCount), 32'(vecs[v].exp_cnt));
    end
    read_all("table", exp_regs);
    @(negedge clock);

    // Same-cycle read of the register being written, on both ports.
`ifdef WB_BYPASS_EN
    pre7 = 16'hA5A5;
`else
    pre7 = 16'h0000;
`endif
    readoutselect = 1'b0;
    aluOutData    = 16'hA5A5;
    WriteRegp4    = 1'b1;
    RegAddressp4  = 3'd7;
    hold          = 1'b0;
    rdAddr1       = 3'd7;
    rdAddr2       = 3'd7;
    #1;
    check("r7_rd1_same_cycle", 32'(rdData1), 32'(pre7));
    check("r7_rd2_same_cycle", 32'(rdData2), 32'(pre7));
    m_regs[7] = 16'hA5A5;
    m_cnt     = m_cnt + CW'(1);
    @(negedge clock);
    WriteRegp4 = 1'b0;
    #1;
    check("r7_rd1_after_edge", 32'(rdData1), 32'hA5A5);
    check("r7_rd2_after_edge", 32'(rdData2), 32'hA5A5);
    check("r7_fwdAddr", 32'(fwdAddr), 32'd7);
    check("r7_wbCount", 32'(wbCount), 32'd6);
    @(negedge clock);

    // Drive the counter to all-ones, then one more write must wrap it to zero.
    while (m_cnt != {CW{1'b1}}) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b1,
            3'($urandom_range(0, 7)), 1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    check("count_all_ones", 32'(wbCount), 32'(8'hFF));
    cycle(1'b0, 16'h0000, 16'h3C3C, 1'b1, 3'd6, 1'b0, 3'd6, 3'd1);
    check("count_wrap_zero", 32'(wbCount), 32'd0);
    read_all("post_wrap", m_regs);
    @(negedge clock);

    // Async reset between edges with a write pending: everything clears, write lost.
    readoutselect = 1'b0;
    aluOutData    = 16'h9999;
    WriteRegp4    = 1'b1;
    RegAddressp4  = 3'd1;
    hold          = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_fwdValid", 32'(fwdValid), 32'd0);
    check("async_fwdAddr", 32'(fwdAddr), 32'd0);
    check("async_fwdData", 32'(fwdData), 32'd0);
    check("async_wbCount", 32'(wbCount), 32'd0);
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_cnt = '0;
    sbq.delete();
    read_all("async", zeros);
    @(negedge clock);
    rdAddr1 = 3'd1;
    #1;
    check("async_write_lost", 32'(rdData1), 32'd0);
    @(negedge clock);

    // First write after release commits on the very next rising edge.
    reset_n = 1'b1;
    cycle(1'b1, 16'h4242, 16'h0000, 1'b1, 3'd1, 1'b0, 3'd1, 3'd2);
    check("post_reset_fwdData", 32'(fwdData), 32'h4242);
    check("post_reset_wbCount", 32'(wbCount), 32'd1);
    WriteRegp4 = 1'b0;
    rdAddr1    = 3'd1;
    #1;
    check("post_reset_r1", 32'(rdData1), 32'h4242);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have parameter RESET_VALUE, default 16'h0000, the reset value of all eight registers.
REQ-002 The block SHALL have parameter COUNT_WIDTH, default 16, the width of wbCount.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port readOutData, input, 16 bits: load data from the memory stage.
REQ-006 The block SHALL have port aluOutData, input, 16 bits: registered ALU result from the memory stage.
REQ-007 The block SHALL have port readoutselect, input, 1 bit: 1 selects readOutData, 0 selects aluOutData.
REQ-008 The block SHALL have port WriteRegp4, input, 1 bit: register write request.
REQ-009 The block SHALL have port RegAddressp4, input, 3 bits: destination register.
REQ-010 The block SHALL have port hold, input, 1 bit: stage stall; 1 suppresses the write.
REQ-011 The block SHALL have ports rdAddr1 and rdAddr2, input, 3 bits each: decode-stage read addresses.
REQ-012 The block SHALL have ports rdData1 and rdData2, output, 16 bits each: combinational read data.
REQ-013 The block SHALL have ports fwdValid (1 bit), fwdAddr (3 bits) and fwdData (16 bits), output, registered: last-written register, for execute-stage forwarding.
REQ-014 The block SHALL have port wbCount, output, COUNT_WIDTH bits: registered count of committed writes.

Function
REQ-015 wbData SHALL be readOutData when readoutselect=1 and aluOutData otherwise, with no added latency.
REQ-016 A write SHALL commit when WriteRegp4=1 and hold=0; regs[RegAddressp4] <= wbData on that rising edge.
REQ-017 All eight registers SHALL be writable; register 0 SHALL NOT be hardwired.
REQ-018 rdDataN SHALL be regs[rdAddrN] combinationally; both ports are independent and may use the same address.
REQ-019 On a committing edge: fwdValid<=1, fwdAddr<=RegAddressp4, fwdData<=wbData; otherwise fwdValid<=0, with fwdAddr and fwdData holding.
REQ-020 wbCount SHALL increment by 1 per committed write and wrap from all-ones to 0 without saturating.
REQ-021 With hold=1, the registers, fwdAddr, fwdData and wbCount SHALL hold, and fwdValid SHALL be 0 on the next edge.
REQ-022 Writes to the same address on consecutive cycles SHALL each commit; the later write wins.

Reset
REQ-023 While reset_n=0, regardless of clock: all regs=RESET_VALUE, fwdValid=0, fwdAddr=0, fwdData=0, wbCount=0.
REQ-024 A write request coincident with reset assertion SHALL be discarded.
REQ-025 The first write SHALL commit on the first rising edge after reset_n deasserts.

Configuration
REQ-026 Macro WB_BYPASS_EN SHALL control write-through bypass.
REQ-027 With WB_BYPASS_EN defined: if a write commits this cycle and rdAddrN==RegAddressp4, rdDataN SHALL equal wbData in the same cycle.
REQ-028 Without WB_BYPASS_EN: rdDataN SHALL return the pre-write value until the edge; all other behaviour is unchanged.

Verification
REQ-029 Reset, then read all 8 addresses -> every rdData = 16'h0000; wbCount=0; fwdValid=0.
REQ-030 readoutselect=0, aluOutData=16'h1234, write to r3; then readoutselect=1, readOutData=16'hBEEF, write to r5 -> r3=16'h1234, r5=16'hBEEF; fwdAddr/fwdData track each write; wbCount=2.
REQ-031 WriteRegp4=1, hold=1, address r2, data 16'h5555 -> r2 unchanged; fwdValid=0; wbCount unchanged.
REQ-032 Write 16'hA5A5 to r7 with rdAddr1=rdAddr2=7 in the same cycle -> rdData=16'hA5A5 before the edge with WB_BYPASS_EN; old value without it.
REQ-033 Preload wbCount to all-ones by writes, commit one more -> wbCount=0.
REQ-034 Assert reset_n=0 mid-stream, asynchronously between edges -> all regs, fwd* and wbCount clear immediately; a write pending on that cycle is lost.
